axisv_lcd_out: RTL and testbench

- Downstream stage of the AXI4-Stream video test-pattern generator.
- Free-running LCD raster timing generator: produces hsync/vsync/de from porch/sync parameters.
- Pulls one AXIS beat per active pixel and drives it onto the parallel LCD bus.
- Checks stream framing against the raster; on underflow or misalignment it blanks output, flushes to end of frame and re-locks at the next raster frame start.

---
 rtl/axisv_lcd_out.sv | 94 +++++++++
 tb/tb_axisv_lcd_out.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/axisv_lcd_out.sv
// axisv_lcd_out: LCD raster timing generator fed by an AXI4-Stream pixel source, with framing checks and re-lock.
module axisv_lcd_out #(
  parameter int H_PIXEL_COUNT = 8,
  parameter int H_FRONT_PORCH = 1,
  parameter int H_SYNC        = 1,
  parameter int H_BACK_PORCH  = 1,
  parameter int V_PIXEL_COUNT = 4,
  parameter int V_FRONT_PORCH = 1,
  parameter int V_SYNC        = 1,
  parameter int V_BACK_PORCH  = 1,
  parameter int DATA_WIDTH    = 18
) (
  input  logic                  aclk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [1:0]            s_axis_tuser,
  output logic [DATA_WIDTH-1:0] lcd_data_o,
  output logic                  lcd_de_o,
  output logic                  lcd_hsync_o,
  output logic                  lcd_vsync_o,
  output logic                  underflow_o,
  output logic                  misalign_o,
  output logic                  locked_o
);
  localparam int H_TOTAL = H_PIXEL_COUNT + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH;
  localparam int V_TOTAL = V_PIXEL_COUNT + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int HS_BEG = H_PIXEL_COUNT + H_FRONT_PORCH;
  localparam int VS_BEG = V_PIXEL_COUNT + V_FRONT_PORCH;

  typedef enum logic [1:0] {ARM, LOCKED, FLUSH} state_t;

  state_t        state;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_end, v_end, active, eol, eof, bad, hs_low, vs_low, unused_tuser;

  assign unused_tuser = s_axis_tuser[1];

  always_comb begin
    h_end  = int'(h_cnt) == H_TOTAL - 1;
    v_end  = int'(v_cnt) == V_TOTAL - 1;
    active = int'(h_cnt) < H_PIXEL_COUNT && int'(v_cnt) < V_PIXEL_COUNT;
    eol    = int'(h_cnt) == H_PIXEL_COUNT - 1;
    eof    = eol && int'(v_cnt) == V_PIXEL_COUNT - 1;
    hs_low = int'(h_cnt) >= HS_BEG && int'(h_cnt) < HS_BEG + H_SYNC;
    vs_low = int'(v_cnt) >= VS_BEG && int'(v_cnt) < VS_BEG + V_SYNC;
    bad    = s_axis_tlast != eol || s_axis_tuser[0] != eof;
    s_axis_tready = state == LOCKED ? active : state == FLUSH;
    locked_o = state == LOCKED;
  end

  always_ff @(posedge aclk_i) begin
    if (rst_i) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_end ? '0 : h_cnt + 1'b1;
      if (h_end)
        v_cnt <= v_end ? '0 : v_cnt + 1'b1;
    end
  end

  // Syncs and de always follow the raster; only data is gated by lock state.
  always_ff @(posedge aclk_i) begin
    if (rst_i) begin
      state       <= ARM;
      lcd_data_o  <= '0;
      lcd_de_o    <= 1'b0;
      lcd_hsync_o <= 1'b1;
      lcd_vsync_o <= 1'b1;
      underflow_o <= 1'b0;
      misalign_o  <= 1'b0;
    end else begin
      lcd_de_o    <= active;
      lcd_hsync_o <= !hs_low;
      lcd_vsync_o <= !vs_low;
      lcd_data_o  <= (state == LOCKED && active && s_axis_tvalid) ? s_axis_tdata : '0;
      underflow_o <= state == LOCKED && active && !s_axis_tvalid;
      misalign_o  <= state == LOCKED && active && s_axis_tvalid && bad;
      case (state)
        ARM:     if (h_end && v_end) state <= LOCKED;
        LOCKED:  if (active && (!s_axis_tvalid || bad))
                   state <= (s_axis_tvalid && s_axis_tuser[0]) ? ARM : FLUSH;
        FLUSH:   if (s_axis_tvalid && s_axis_tuser[0]) state <= ARM;
        default: state <= ARM;
      endcase
    end
  end
endmodule

// File: tb/tb_axisv_lcd_out.sv
// tb_axisv_lcd_out: directed scenarios for axisv_lcd_out at default geometry (11 x 7 raster, 8 x 4 active).
module tb_axisv_lcd_out;
  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] tdata;
  logic        tvalid, tready, tlast;
  logic [1:0]  tuser;
  logic [17:0] lcd_data;
  logic        de, hsync, vsync, uf, ma, lk;
  int          errors = 0, checks = 0;
  int          n, idx, drop_n;
  bit          src_en, inj_last, inj_eof;

  always #5 clk = ~clk;

  axisv_lcd_out dut (
    .aclk_i(clk), .rst_i(rst),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
    .s_axis_tlast(tlast), .s_axis_tuser(tuser),
    .lcd_data_o(lcd_data), .lcd_de_o(de), .lcd_hsync_o(hsync), .lcd_vsync_o(vsync),
    .underflow_o(uf), .misalign_o(ma), .locked_o(lk)
  );

  // Source presents beat idx of a 32-pixel frame (data = v*8 + h), optionally corrupted.
  task automatic drive();
    tvalid = src_en && n != drop_n;
    tdata  = 18'(idx);
    tlast  = (idx % 8 == 7) || (inj_last && idx == 5);
    tuser  = {1'b0, (idx == 31) || (inj_eof && idx == 23)};
  endtask

  // After this returns, n is the raster position held by the counters; outputs reflect position n-1.
  task automatic tick();
    bit hs_now, eof_now;
    hs_now  = tvalid && tready;
    eof_now = tuser[0];
    @(posedge clk);
    #1;
    n++;
    if (hs_now) begin
      if (idx == 5) inj_last = 0;
      if (idx == 23) inj_eof = 0;
      idx = eof_now ? 0 : idx + 1;
    end
    drive();
  endtask

  task automatic reset_dut();
    rst = 1; src_en = 0; drop_n = -1; inj_last = 0; inj_eof = 0; idx = 0; n = 0;
    drive();
    tick();
    tick();
    rst = 0; n = 0; idx = 0;
    drive();
  endtask

  function automatic void geo(input int nn, output int h, output int v, output int f, output bit act);
    int p;
    p = nn - 1;
    h = p % 11;
    v = (p / 11) % 7;
    f = p / 77;
    act = h < 8 && v < 4;
  endfunction

  function automatic logic [23:0] expv(input int d, input bit de_e, hs_e, vs_e, uf_e, ma_e, lk_e);
    return {18'(d), de_e, hs_e, vs_e, uf_e, ma_e, lk_e};
  endfunction

  task automatic test_reset();
    reset_dut();
    checks++;
    if ({lcd_data, de, hsync, vsync, uf, ma, lk} !== expv(0, 0, 1, 1, 0, 0, 0)) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=%h", {lcd_data, de, hsync, vsync, uf, ma, lk}, expv(0, 0, 1, 1, 0, 0, 0));
    end
    checks++;
    if (tready !== 1'b0) begin errors++; $display("FAIL reset_tready got=%b exp=0", tready); end
  endtask

  task automatic test_raster();
    int h, v, f;
    bit act;
    logic [23:0] e;
    reset_dut();
    for (int k = 0; k < 160; k++) begin
      tick();
      geo(n, h, v, f, act);
      e = expv(0, act, h != 9, v != 5, n == 78, 0, n == 77);
      checks++;
      if ({lcd_data, de, hsync, vsync, uf, ma, lk} !== e) begin
        errors++;
        $display("FAIL raster n=%0d got=%h exp=%h", n, {lcd_data, de, hsync, vsync, uf, ma, lk}, e);
      end
      checks++;
      if (tready !== (n >= 77)) begin errors++; $display("FAIL raster_tready n=%0d got=%b exp=%b", n, tready, n >= 77); end
    end
  endtask

  task automatic test_stream();
    int h, v, f;
    bit act;
    logic [23:0] e;
    reset_dut();
    src_en = 1;
    drive();
    for (int k = 0; k < 308; k++) begin
      tick();
      geo(n, h, v, f, act);
      e = expv((f >= 1 && act) ? v * 8 + h : 0, act, h != 9, v != 5, 0, 0, n >= 77);
      checks++;
      if ({lcd_data, de, hsync, vsync, uf, ma, lk} !== e) begin
        errors++;
        $display("FAIL stream n=%0d got=%h exp=%h", n, {lcd_data, de, hsync, vsync, uf, ma, lk}, e);
      end
    end
  endtask

  task automatic test_underflow();
    int h, v, f;
    bit act;
    logic [23:0] e;
    reset_dut();
    src_en = 1; drop_n = 91;
    drive();
    for (int k = 0; k < 231; k++) begin
      tick();
      geo(n, h, v, f, act);
      e = expv((f >= 1 && act && !(f == 1 && n - 1 >= 91)) ? v * 8 + h : 0, act, h != 9, v != 5,
               n == 92, 0, (n >= 77 && n <= 91) || n >= 154);
      checks++;
      if ({lcd_data, de, hsync, vsync, uf, ma, lk} !== e) begin
        errors++;
        $display("FAIL underflow n=%0d got=%h exp=%h", n, {lcd_data, de, hsync, vsync, uf, ma, lk}, e);
      end
      if (n >= 92 && n <= 113) begin
        checks++;
        if (tready !== (n <= 112)) begin errors++; $display("FAIL underflow_tready n=%0d got=%b exp=%b", n, tready, n <= 112); end
      end
    end
  endtask

  task automatic test_misalign();
    int h, v, f;
    bit act;
    logic [23:0] e;
    reset_dut();
    src_en = 1; inj_last = 1;
    drive();
    for (int k = 0; k < 231; k++) begin
      tick();
      geo(n, h, v, f, act);
      e = expv((f >= 1 && act && !(f == 1 && n - 1 >= 83)) ? v * 8 + h : 0, act, h != 9, v != 5,
               0, n == 83, (n >= 77 && n <= 82) || n >= 154);
      checks++;
      if ({lcd_data, de, hsync, vsync, uf, ma, lk} !== e) begin
        errors++;
        $display("FAIL misalign n=%0d got=%h exp=%h", n, {lcd_data, de, hsync, vsync, uf, ma, lk}, e);
      end
      if (n >= 83 && n <= 109) begin
        checks++;
        if (tready !== (n <= 108)) begin errors++; $display("FAIL misalign_tready n=%0d got=%b exp=%b", n, tready, n <= 108); end
      end
    end
  endtask

  task automatic test_early_eof();
    int h, v, f;
    bit act;
    logic [23:0] e;
    reset_dut();
    src_en = 1; inj_eof = 1;
    drive();
    for (int k = 0; k < 231; k++) begin
      tick();
      geo(n, h, v, f, act);
      e = expv((f >= 1 && act && !(f == 1 && n - 1 >= 107)) ? v * 8 + h : 0, act, h != 9, v != 5,
               0, n == 107, (n >= 77 && n <= 106) || n >= 154);
      checks++;
      if ({lcd_data, de, hsync, vsync, uf, ma, lk} !== e) begin
        errors++;
        $display("FAIL early_eof n=%0d got=%h exp=%h", n, {lcd_data, de, hsync, vsync, uf, ma, lk}, e);
      end
      if (n >= 107 && n <= 153) begin
        checks++;
        if (tready !== 1'b0) begin errors++; $display("FAIL early_eof_tready n=%0d got=%b exp=0", n, tready); end
      end
    end
  endtask

  task automatic test_mid_reset();
    int h, v, f;
    bit act;
    logic [23:0] e;
    reset_dut();
    src_en = 1;
    drive();
    while (n < 95) tick();
    rst = 1;
    tick();
    checks++;
    if ({lcd_data, de, hsync, vsync, uf, ma, lk} !== expv(0, 0, 1, 1, 0, 0, 0)) begin
      errors++;
      $display("FAIL mid_reset_outputs got=%h exp=%h", {lcd_data, de, hsync, vsync, uf, ma, lk}, expv(0, 0, 1, 1, 0, 0, 0));
    end
    checks++;
    if (tready !== 1'b0) begin errors++; $display("FAIL mid_reset_tready got=%b exp=0", tready); end
    rst = 0; n = 0; idx = 0;
    drive();
    for (int k = 0; k < 154; k++) begin
      tick();
      geo(n, h, v, f, act);
      e = expv((f >= 1 && act) ? v * 8 + h : 0, act, h != 9, v != 5, 0, 0, n >= 77);
      checks++;
      if ({lcd_data, de, hsync, vsync, uf, ma, lk} !== e) begin
        errors++;
        $display("FAIL mid_reset n=%0d got=%h exp=%h", n, {lcd_data, de, hsync, vsync, uf, ma, lk}, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_raster();
    test_stream();
    test_underflow();
    test_misalign();
    test_early_eof();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
